// File: rtl/botoes_pkg.sv
// Shared types and constants for the push-button conditioning stage.
package botoes_pkg;

    typedef enum logic [1:0] {
        SOLTO,
        CONF_PRESS,
        PRESSIONADO,
        CONF_SOLTO
    } estado_t;

    localparam int         DEBOUNCE_CICLOS_PADRAO = 50000;
    localparam logic [7:0] JOGADAS_MAX            = 8'd255;

endpackage

// File: rtl/debounce_botao.sv
// One button: 2-flop synchroniser followed by a four-state debounce FSM.
// fire is combinational and marks the edge on which a press is accepted.
module debounce_botao
    import botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic clk,
    input  logic rst,
    input  logic entrada,
    output logic fire,
    output logic estavel
);

    localparam int              CW      = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0]   CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        s1_d     = entrada;
        s2_d     = s1_q;
        estado_d = estado_q;
        cnt_d    = cnt_q;
        fire     = 1'b0;
        case (estado_q)
            SOLTO: begin
                if (s2_q) begin
                    estado_d = CONF_PRESS;
                    cnt_d    = '0;
                end
            end
            CONF_PRESS: begin
                if (!s2_q) begin
                    estado_d = SOLTO;
                end else if (cnt_q == CNT_FIM) begin
                    estado_d = PRESSIONADO;
                    fire     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSIONADO: begin
                if (!s2_q) begin
                    estado_d = CONF_SOLTO;
                    cnt_d    = '0;
                end
            end
            CONF_SOLTO: begin
                // Release is silent: only the press direction produces a fire.
                if (s2_q) begin
                    estado_d = PRESSIONADO;
                end else if (cnt_q == CNT_FIM) begin
                    estado_d = SOLTO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: estado_d = SOLTO;
        endcase
    end

    // NOTE: reset is synchronous, so rst is sampled by the edge and stays out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the synchroniser really is two stages.
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            estado_q <= SOLTO;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    assign estavel = (estado_q == PRESSIONADO) || (estado_q == CONF_SOLTO);

endmodule

// File: rtl/botoes_condicionador.sv
// Button input stage: polarity fix, per-bit debounce, play-enable gating,
// single-cycle press pulses and a saturating move counter.
module botoes_condicionador
    import botoes_pkg::*;
#(
    parameter int N_BOTOES            = 8,
    parameter int DEBOUNCE_CICLOS     = DEBOUNCE_CICLOS_PADRAO,
    parameter int ENTRADA_ATIVA_BAIXA = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] botoes_raw,
    input  logic                habilita,
    input  logic                limpa_jogadas,
    output logic [N_BOTOES-1:0] pulsos,
    output logic [N_BOTOES-1:0] estavel,
    output logic                algum_pulso,
    output logic [7:0]          jogadas
);

    logic [N_BOTOES-1:0] entrada;
    logic [N_BOTOES-1:0] fire;
    logic [N_BOTOES-1:0] pulsos_q, pulsos_d;
    logic [7:0]          jogadas_q, jogadas_d;

    assign entrada = (ENTRADA_ATIVA_BAIXA != 0) ? ~botoes_raw : botoes_raw;

    for (genvar k = 0; k < N_BOTOES; k++) begin : g_botao
        debounce_botao #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .entrada (entrada[k]),
            .fire    (fire[k]),
            .estavel (estavel[k])
        );
    end

    // A fire while disabled is dropped for good; the FSM has already moved on.
    always_comb begin
        pulsos_d  = habilita ? fire : '0;
        jogadas_d = jogadas_q;
        if (limpa_jogadas) begin
            jogadas_d = '0;
        end else if ((|pulsos_d) && (jogadas_q != JOGADAS_MAX)) begin
            jogadas_d = jogadas_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pulsos_q  <= '0;
            jogadas_q <= '0;
        end else begin
            pulsos_q  <= pulsos_d;
            jogadas_q <= jogadas_d;
        end
    end

    assign pulsos      = pulsos_q;
    assign algum_pulso = |pulsos_q;
    assign jogadas     = jogadas_q;

endmodule
